// File: rtl/vga_timing_gen_if.sv
// Pixel timing bus: advance strobe in, coordinates, sync, enable and markers out.
interface vga_timing_gen_if;
   localparam int unsigned CW = 10;
   localparam int unsigned FW = 16;

   logic          pix_stb;
   logic [CW-1:0] sx;
   logic [CW-1:0] sy;
   logic          hsync;
   logic          vsync;
   logic          de;
   logic          line_start;
   logic          frame_start;
   logic [FW-1:0] frame_count;

   modport master (
      input  pix_stb,
      output sx, sy, hsync, vsync, de, line_start, frame_start, frame_count
   );

   modport slave (
      output pix_stb,
      input  sx, sy, hsync, vsync, de, line_start, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// data-enable and line/frame markers, all describing the same (sx,sy).
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0
) (
   input  logic              clk_pix,
   input  logic              rst_pix,
   vga_timing_gen_if.master  vga
);

   localparam int unsigned CW       = 10;
   localparam int unsigned FW       = 16;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   // Counters are CW bits wide, so totals beyond 2^CW cannot be represented.
   if (H_TOTAL > 1024) begin : g_bad_h_total
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
   end
   if (V_TOTAL > 1024) begin : g_bad_v_total
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
   end

   logic [CW-1:0] sx_q, sx_d;
   logic [CW-1:0] sy_q, sy_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          de_q, de_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic [FW-1:0] frame_count_q, frame_count_d;

   // Next position and its decode; markers only fire on a strobed advance.
   always_comb begin
      sx_d          = sx_q;
      sy_d          = sy_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      de_d          = de_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_count_d = frame_count_q;

      if (vga.pix_stb) begin
         if (32'(sx_q) == H_TOTAL - 1) begin
            sx_d = '0;
            sy_d = (32'(sy_q) == V_TOTAL - 1) ? '0 : sy_q + CW'(1);
         end else begin
            sx_d = sx_q + CW'(1);
         end

         de_d          = (32'(sx_d) < H_ACTIVE) && (32'(sy_d) < V_ACTIVE);
         hsync_d       = ((32'(sx_d) >= HS_START) && (32'(sx_d) < HS_END)) ? H_POL : ~H_POL;
         vsync_d       = ((32'(sy_d) >= VS_START) && (32'(sy_d) < VS_END)) ? V_POL : ~V_POL;
         line_start_d  = (sx_d == '0);
         frame_start_d = (sx_d == '0) && (sy_d == '0);
         frame_count_d = frame_count_q + FW'(frame_start_d);
      end
   end

   // State and output registers; reset parks on the last pixel of the frame.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         sx_q          <= CW'(H_TOTAL - 1);
         sy_q          <= CW'(V_TOTAL - 1);
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         sx_q          <= sx_d;
         sy_q          <= sy_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign vga.sx          = sx_q;
   assign vga.sy          = sy_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.de          = de_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;
   assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small-geometry
// instance (short frames, inverted hsync polarity) checked against a
// position-from-strobe-count reference model.
module tb_vga_timing_gen;

   typedef struct packed {
      int unsigned ha, hf, hsw, hb;
      int unsigned va, vf, vsw, vb;
      logic        hp, vp;
   } cfg_t;

   typedef struct packed {
      logic [9:0]  sx;
      logic [9:0]  sy;
      logic        hs;
      logic        vs;
      logic        de;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } exp_t;

   typedef struct {
      logic rst;
      logic stb;
      exp_t want;
   } vec_t;

   localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
   localparam cfg_t CFG_B = '{16, 2, 3, 4, 8, 2, 2, 3, 1'b1, 1'b0};

   logic clk_pix = 1'b0;
   logic rst_a;
   logic rst_b;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   // Reference-model state: strobes since reset and whether the last edge advanced.
   int unsigned ka = 0, kb = 0;
   bit          pa = 0, pb = 0;
   bit          chk_a = 0, chk_b = 0;

   vga_timing_gen_if if_a ();
   vga_timing_gen_if if_b ();

   vga_timing_gen u_a (
      .clk_pix (clk_pix),
      .rst_pix (rst_a),
      .vga     (if_a.master)
   );

   vga_timing_gen #(
      .H_ACTIVE (CFG_B.ha),  .H_FP (CFG_B.hf), .H_SYNC (CFG_B.hsw), .H_BP (CFG_B.hb),
      .V_ACTIVE (CFG_B.va),  .V_FP (CFG_B.vf), .V_SYNC (CFG_B.vsw), .V_BP (CFG_B.vb),
      .H_POL    (CFG_B.hp),  .V_POL (CFG_B.vp)
   ) u_b (
      .clk_pix (clk_pix),
      .rst_pix (rst_b),
      .vga     (if_b.master)
   );

   always #5 clk_pix = ~clk_pix;

   // Expected outputs after k strobes since reset, derived from raster position.
   function automatic exp_t model(cfg_t c, int unsigned k, bit pulse);
      int unsigned ht, vt, ft, p, x, y;
      exp_t e;
      ht = c.ha + c.hf + c.hsw + c.hb;
      vt = c.va + c.vf + c.vsw + c.vb;
      ft = ht * vt;
      if (k == 0) begin
         e = '{10'(ht - 1), 10'(vt - 1), ~c.hp, ~c.vp, 1'b0, 1'b0, 1'b0, 16'h0};
      end else begin
         p    = (k - 1) % ft;
         x    = p % ht;
         y    = p / ht;
         e.sx = 10'(x);
         e.sy = 10'(y);
         e.de = (x < c.ha) && (y < c.va);
         e.hs = (x >= c.ha + c.hf && x < c.ha + c.hf + c.hsw) ? c.hp : ~c.hp;
         e.vs = (y >= c.va + c.vf && y < c.va + c.vf + c.vsw) ? c.vp : ~c.vp;
         e.ls = pulse && (x == 0);
         e.fs = pulse && (p == 0);
         e.fc = 16'((k - 1) / ft + 1);
      end
      return e;
   endfunction

   function automatic exp_t mk(int sx, int sy, bit hs, bit vs, bit de, bit ls, bit fs, int fc);
      return '{10'(sx), 10'(sy), hs, vs, de, ls, fs, 16'(fc)};
   endfunction

   function automatic exp_t got_a();
      return {if_a.sx, if_a.sy, if_a.hsync, if_a.vsync, if_a.de,
              if_a.line_start, if_a.frame_start, if_a.frame_count};
   endfunction

   function automatic exp_t got_b();
      return {if_b.sx, if_b.sy, if_b.hsync, if_b.vsync, if_b.de,
              if_b.line_start, if_b.frame_start, if_b.frame_count};
   endfunction

   task automatic chk_e(string name, exp_t got, exp_t want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s @%0t: got sx=%0d sy=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%h, want sx=%0d sy=%0d hs=%b vs=%b de=%b ls=%b fs=%b fc=%h",
                  name, $time, got.sx, got.sy, got.hs, got.vs, got.de, got.ls, got.fs, got.fc,
                  want.sx, want.sy, want.hs, want.vs, want.de, want.ls, want.fs, want.fc);
      end
   endtask

   task automatic chk_i(string name, int got, int want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
      end
   endtask

   // One clock: advance the model on the edge, then compare just after it.
   task automatic step();
      @(posedge clk_pix);
      if (rst_a) begin ka = 0; pa = 0; end
      else if (if_a.pix_stb) begin ka++; pa = 1; end
      else pa = 0;
      if (rst_b) begin kb = 0; pb = 0; end
      else if (if_b.pix_stb) begin kb++; pb = 1; end
      else pb = 0;
      #1;
      if (chk_a) chk_e("model_a", got_a(), model(CFG_A, ka, pa));
      if (chk_b) chk_e("model_b", got_b(), model(CFG_B, kb, pb));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vec[11];
      exp_t ra;
      int   de_n, hs_n, ls_n, fs_n, vs_n, last, last_stb, stb_n, run, maxrun;
      bit   found;

      rst_a = 1'b1; rst_b = 1'b1;
      if_a.pix_stb = 1'b0; if_b.pix_stb = 1'b0;

      // Reset, hold and first-advance vectors on the default geometry.
      ra = mk(799, 524, 1, 1, 0, 0, 0, 0);
      vec[0]  = '{1'b1, 1'b0, ra};
      vec[1]  = '{1'b1, 1'b1, ra};
      vec[2]  = '{1'b1, 1'b1, ra};
      vec[3]  = '{1'b0, 1'b0, ra};
      vec[4]  = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 1)};
      vec[5]  = '{1'b0, 1'b1, mk(1, 0, 1, 1, 1, 0, 0, 1)};
      vec[6]  = '{1'b0, 1'b0, mk(1, 0, 1, 1, 1, 0, 0, 1)};
      vec[7]  = '{1'b0, 1'b1, mk(2, 0, 1, 1, 1, 0, 0, 1)};
      vec[8]  = '{1'b1, 1'b0, ra};
      vec[9]  = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 1)};
      vec[10] = '{1'b0, 1'b1, mk(1, 0, 1, 1, 1, 0, 0, 1)};
      for (int i = 0; i < 11; i++) begin
         rst_a = vec[i].rst;
         if_a.pix_stb = vec[i].stb;
         step();
         chk_e($sformatf("vec%0d", i), got_a(), vec[i].want);
      end
      chk_a = 1;

      // Align to the last pixel of a line, then measure two full lines.
      if_a.pix_stb = 1'b1;
      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         step();
         found = (if_a.sx == 10'd799);
      end
      chk_i("align_a", int'(found), 1);
      de_n = 0; hs_n = 0; ls_n = 0; last = 0;
      for (int i = 0; i < 1600; i++) begin
         step();
         if (if_a.de) de_n++;
         if (!if_a.hsync) hs_n++;
         if (if_a.line_start) begin
            if (ls_n > 0) chk_i("ls_period", i - last, 800);
            ls_n++; last = i;
         end
      end
      chk_i("de_cycles_2lines", de_n, 1280);
      chk_i("hsync_low_2lines", hs_n, 192);
      chk_i("ls_count_2lines", ls_n, 2);

      // Half-rate strobe: markers stay single-cycle, period counted in strobes.
      ls_n = 0; stb_n = 0; last_stb = 0; last = 0; run = 0; maxrun = 0;
      for (int i = 0; i < 1700; i++) begin
         if_a.pix_stb = (i % 2 == 0);
         if (if_a.pix_stb) stb_n++;
         step();
         if (if_a.line_start) begin
            run++;
            if (ls_n > 0) begin
               chk_i("ls_period_strobes", stb_n - last_stb, 800);
               chk_i("ls_period_cycles", i - last, 1600);
            end
            ls_n++; last_stb = stb_n; last = i;
         end else begin
            run = 0;
         end
         if (run > maxrun) maxrun = run;
      end
      chk_i("ls_count_toggle", ls_n, 2);
      chk_i("ls_width_toggle", maxrun, 1);
      if_a.pix_stb = 1'b0;

      // Small geometry: three whole frames from reset release.
      chk_b = 1;
      rst_b = 1'b0;
      if_b.pix_stb = 1'b1;
      vs_n = 0; de_n = 0; fs_n = 0; last = 0;
      for (int i = 0; i < 1125; i++) begin
         step();
         if (!if_b.vsync) vs_n++;
         if (if_b.de) de_n++;
         if (if_b.frame_start) begin
            if (fs_n > 0) chk_i("fs_period", i - last, 375);
            fs_n++; last = i;
            chk_i("fc_at_fs", int'(if_b.frame_count), fs_n);
         end
      end
      chk_i("vsync_low_3frames", vs_n, 150);
      chk_i("de_cycles_3frames", de_n, 384);
      chk_i("fs_count_3frames", fs_n, 3);

      // Reset mid-frame for three cycles, then restart at the origin.
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         step();
         found = (if_b.sx == 10'd10) && (if_b.sy == 10'd5);
      end
      chk_i("reach_mid_b", int'(found), 1);
      rst_b = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk_e("mid_reset_b", got_b(), mk(24, 14, 0, 1, 0, 0, 0, 0));
      rst_b = 1'b0;
      step();
      chk_e("restart_b", got_b(), mk(0, 0, 0, 1, 1, 1, 1, 1));

      // Randomised strobe and occasional reset against the model.
      for (int i = 0; i < 20000; i++) begin
         if_b.pix_stb = ($urandom_range(0, 3) != 0);
         rst_b = ($urandom_range(0, 1999) == 0);
         step();
      end
      rst_b = 1'b0;

      // frame_count wrap: preload all-ones, next frame_start rolls it to zero.
      chk_b = 0;
      if_b.pix_stb = 1'b1;
      step();
      force u_b.frame_count_q = 16'hFFFF;
      step();
      release u_b.frame_count_q;
      chk_i("fc_preload", int'(if_b.frame_count), 16'hFFFF);
      found = 0;
      for (int i = 0; i < 400 && !found; i++) begin
         step();
         found = if_b.frame_start;
      end
      chk_i("fs_after_preload", int'(found), 1);
      chk_i("fc_wrap", int'(if_b.frame_count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
